// File: rtl/perf_pkg.sv
// Shared constants and helpers for the performance-counter CSR block.
package perf_pkg;

  // Register byte offsets (word aligned; addr[1:0] ignored by the decoder)
  localparam logic [7:0] PERF_CYCLE  = 8'h10;
  localparam logic [7:0] PERF_INSTR  = 8'h14;
  localparam logic [7:0] PERF_RST    = 8'h18;
  localparam logic [7:0] PERF_BR_TOT = 8'h1C;
  localparam logic [7:0] PERF_BR_OK  = 8'h20;
  localparam logic [7:0] PERF_CTRL   = 8'h24;

  // Control register bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_FRZ = CTRL_EN + 1;

  localparam int NUM_CTR = 4;

  // Slot of each counter inside the packed counter array
  typedef enum logic [1:0] {
    CTR_CYCLE  = 2'd0,
    CTR_INSTR  = 2'd1,
    CTR_BR_TOT = 2'd2,
    CTR_BR_OK  = 2'd3
  } ctr_idx_e;

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } perf_state_e;

  // Counting state is a pure function of the two control bits
  function automatic perf_state_e ctrl_state(input logic en, input logic frz);
    if (!en)     return ST_STOP;
    else if (frz) return ST_FROZEN;
    else          return ST_RUN;
  endfunction

endpackage

// File: rtl/perf_counter_csr_if.sv
// MMIO bus between the address decoder / CPU and the perf-counter CSR block.
interface perf_counter_csr_if;
  logic        sel;
  logic [7:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, addr, we, re, wdata, input rdata);
  modport slave  (input sel, addr, we, re, wdata, output rdata);
endinterface

// File: rtl/perf_ctr.sv
// Single wrapping event counter; clear beats increment.
module perf_ctr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         run,
  output logic [W-1:0] q
);

  // Clear wins over a same-cycle event; otherwise count while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          q <= '0;
    else if (clr)        q <= '0;
    else if (run && inc) q <= q + W'(1);
  end

endmodule

// File: rtl/perf_counter_csr.sv
// Cycle / retired-instruction / branch counters exposed as MMIO CSRs.
// Reads return the value sampled at the request edge (before that cycle's
// increments); a control write only affects counting from the next cycle.
module perf_counter_csr
  import perf_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter bit RESET_ENABLE  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     retire,
  input  logic                     br_resolve,
  input  logic                     br_correct,
  perf_counter_csr_if.slave        bus,
  output logic [COUNTER_WIDTH-1:0] cycle_counter,
  output logic [COUNTER_WIDTH-1:0] instruction_counter
);

  if (COUNTER_WIDTH < 1 || COUNTER_WIDTH > 32) begin : g_width_chk
    $error("perf_counter_csr: COUNTER_WIDTH must be 1..32");
  end

  logic                                  ctrl_en, ctrl_frz;
  perf_state_e                           state;
  logic                                  run, wr_hit, clr, ctrl_wr;
  logic [NUM_CTR-1:0]                    inc;
  logic [NUM_CTR-1:0][COUNTER_WIDTH-1:0] cnt;
  logic [31:0]                           rd_mux, rdata_q;
  logic                                  unused;

  assign unused  = ^{bus.addr[1:0], bus.wdata[31:2]};

  assign state   = ctrl_state(ctrl_en, ctrl_frz);
  assign run     = (state == ST_RUN);
  assign wr_hit  = bus.sel & bus.we;
  assign clr     = wr_hit & (bus.addr[7:2] == PERF_RST[7:2]);
  assign ctrl_wr = wr_hit & (bus.addr[7:2] == PERF_CTRL[7:2]);

  assign inc[CTR_CYCLE]  = 1'b1;
  assign inc[CTR_INSTR]  = retire;
  assign inc[CTR_BR_TOT] = br_resolve;
  assign inc[CTR_BR_OK]  = br_resolve & br_correct;

  perf_ctr #(.W(COUNTER_WIDTH)) u_ctr [NUM_CTR-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc),
    .run   (run),
    .q     (cnt)
  );

  // Control register: enable/freeze, changed only by software writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en  <= RESET_ENABLE;
      ctrl_frz <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_en  <= bus.wdata[CTRL_EN];
      ctrl_frz <= bus.wdata[CTRL_FRZ];
    end
  end

  // Read mux over current (pre-write, pre-increment) state, zero-extended
  always_comb begin
    rd_mux = '0;
    case (bus.addr[7:2])
      PERF_CYCLE[7:2]:  rd_mux = 32'(cnt[CTR_CYCLE]);
      PERF_INSTR[7:2]:  rd_mux = 32'(cnt[CTR_INSTR]);
      PERF_BR_TOT[7:2]: rd_mux = 32'(cnt[CTR_BR_TOT]);
      PERF_BR_OK[7:2]:  rd_mux = 32'(cnt[CTR_BR_OK]);
      PERF_CTRL[7:2]: begin
        rd_mux[CTRL_EN]  = ctrl_en;
        rd_mux[CTRL_FRZ] = ctrl_frz;
      end
      default:          rd_mux = '0;
    endcase
  end

  // Registered read data; holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rdata_q <= '0;
    else if (bus.sel & bus.re) rdata_q <= rd_mux;
  end

  assign bus.rdata           = rdata_q;
  assign cycle_counter       = cnt[CTR_CYCLE];
  assign instruction_counter = cnt[CTR_INSTR];

endmodule
